// File: rtl/gpr_file_8x32.sv
// rtl/gpr_file_8x32.sv - eight 32-bit x86 GPRs with size-aware write and registered read select
//
// Purpose: holds EAX..EDI (index 0..7), drives all eight values to the
// downstream 8:1 operand mux and supplies a registered, handshaked select.
// Optional feature macro: GPR_SCOREBOARD_EN (per-register pending bits + read stall).
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   wr_en, wr_addr, wr_size, wr_data write port (size 00 byte, 01 word, 10 dword, 11 none)
//   rd_valid_in, rd_ready_out        read request handshake (input side)
//   rd_addr, rd_size                 read operand encoding
//   rd_valid_out, rd_ready_in        output stage handshake
//   rd_sel, rd_hi_byte, rd_size_out  registered mux select, high-byte flag, size
//   alloc_en, alloc_addr             mark a physical register pending
//   busy                             per-register pending bits
//   r0..r7                           register contents to mux inputs IN0..IN7

module gpr_file_8x32 #(
   parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic [2:0]  wr_addr,
   input  logic [1:0]  wr_size,
   input  logic [31:0] wr_data,
   input  logic        rd_valid_in,
   output logic        rd_ready_out,
   input  logic [2:0]  rd_addr,
   input  logic [1:0]  rd_size,
   output logic        rd_valid_out,
   input  logic        rd_ready_in,
   output logic [2:0]  rd_sel,
   output logic        rd_hi_byte,
   output logic [1:0]  rd_size_out,
   input  logic        alloc_en,
   input  logic [2:0]  alloc_addr,
   output logic [7:0]  busy,
   output logic [31:0] r0,
   output logic [31:0] r1,
   output logic [31:0] r2,
   output logic [31:0] r3,
   output logic [31:0] r4,
   output logic [31:0] r5,
   output logic [31:0] r6,
   output logic [31:0] r7
);

   localparam logic [1:0] SZ_BYTE  = 2'b00;
   localparam logic [1:0] SZ_WORD  = 2'b01;
   localparam logic [1:0] SZ_DWORD = 2'b10;

   logic [31:0] regs [8];
   logic [2:0]  wr_phys;
   logic [2:0]  rd_phys;
   logic        rd_hi;
   logic        stall;
   logic        accept;

   // Byte encodings 4..7 are AH/CH/DH/BH: bits 15:8 of registers 0..3.
   assign wr_phys = (wr_size == SZ_BYTE && wr_addr[2]) ? {1'b0, wr_addr[1:0]} : wr_addr;
   assign rd_hi   = (rd_size == SZ_BYTE) && rd_addr[2];
   assign rd_phys = rd_hi ? {1'b0, rd_addr[1:0]} : rd_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) regs[i] <= RST_VAL;
      end else if (wr_en) begin
         case (wr_size)
            SZ_DWORD: regs[wr_phys]        <= wr_data;
            SZ_WORD:  regs[wr_phys][15:0]  <= wr_data[15:0];
            SZ_BYTE: begin
               if (wr_addr[2]) regs[wr_phys][15:8] <= wr_data[7:0];
               else            regs[wr_phys][7:0]  <= wr_data[7:0];
            end
            default: ;
         endcase
      end
   end

`ifdef GPR_SCOREBOARD_EN
   logic [7:0] busy_q;

   // Clear on write first, then set on alloc, so a same-cycle alloc wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 8'h00;
      end else begin
         logic [7:0] nxt;
         nxt = busy_q;
         if (wr_en && wr_size != 2'b11) nxt[wr_phys] = 1'b0;
         if (alloc_en)                  nxt[alloc_addr] = 1'b1;
         busy_q <= nxt;
      end
   end

   assign busy  = busy_q;
   assign stall = rd_valid_in & busy_q[rd_phys];
`else
   logic unused_alloc;
   assign unused_alloc = ^{alloc_en, alloc_addr};
   assign busy  = 8'h00;
   assign stall = 1'b0;
`endif

   assign rd_ready_out = (!rd_valid_out || rd_ready_in) && !stall;
   assign accept       = rd_valid_in && rd_ready_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid_out <= 1'b0;
         rd_sel       <= 3'd0;
         rd_hi_byte   <= 1'b0;
         rd_size_out  <= 2'b00;
      end else if (accept) begin
         rd_valid_out <= 1'b1;
         rd_sel       <= rd_phys;
         rd_hi_byte   <= rd_hi;
         rd_size_out  <= rd_size;
      end else if (rd_valid_out && rd_ready_in) begin
         rd_valid_out <= 1'b0;
      end
   end

   assign r0 = regs[0];
   assign r1 = regs[1];
   assign r2 = regs[2];
   assign r3 = regs[3];
   assign r4 = regs[4];
   assign r5 = regs[5];
   assign r6 = regs[6];
   assign r7 = regs[7];

endmodule

// File: tb/tb_gpr_file_8x32.sv
// tb/tb_gpr_file_8x32.sv - scoreboard bench for gpr_file_8x32

module tb_gpr_file_8x32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [1:0]  wr_size;
   logic [31:0] wr_data;
   logic        rd_valid_in;
   logic        rd_ready_out;
   logic [2:0]  rd_addr;
   logic [1:0]  rd_size;
   logic        rd_valid_out;
   logic        rd_ready_in;
   logic [2:0]  rd_sel;
   logic        rd_hi_byte;
   logic [1:0]  rd_size_out;
   logic        alloc_en;
   logic [2:0]  alloc_addr;
   logic [7:0]  busy;
   logic [31:0] r0, r1, r2, r3, r4, r5, r6, r7;
   logic [31:0] rv [8];

   gpr_file_8x32 #(.RST_VAL(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_size(wr_size), .wr_data(wr_data),
      .rd_valid_in(rd_valid_in), .rd_ready_out(rd_ready_out),
      .rd_addr(rd_addr), .rd_size(rd_size),
      .rd_valid_out(rd_valid_out), .rd_ready_in(rd_ready_in),
      .rd_sel(rd_sel), .rd_hi_byte(rd_hi_byte), .rd_size_out(rd_size_out),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy(busy),
      .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7)
   );

   always #5 clk = ~clk;

   assign rv[0] = r0; assign rv[1] = r1; assign rv[2] = r2; assign rv[3] = r3;
   assign rv[4] = r4; assign rv[5] = r5; assign rv[6] = r6; assign rv[7] = r7;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] exp_regs [8];
   logic [7:0]  exp_busy;
   logic        exp_valid;
   logic [5:0]  cur;        // {sel, hi, size} of the expected output stage
   logic [5:0]  sb_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] phys(input logic [2:0] a, input logic [1:0] s);
      return (s == 2'b00 && a >= 3'd4) ? a - 3'd4 : a;
   endfunction

   task automatic clr();
      wr_en = 1'b0; rd_valid_in = 1'b0; alloc_en = 1'b0;
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < 8; i++) check($sformatf("%s_r%0d", tag, i), rv[i], exp_regs[i]);
   endtask

   // One clock: check the handshake before the edge, update the model after it
   // and compare the output stage against the scoreboard.
   task automatic step();
      logic exp_ready, acc;
      logic [2:0] p;
      #1;
      p = phys(rd_addr, rd_size);
      exp_ready = (!exp_valid || rd_ready_in) && !(rd_valid_in && exp_busy[p]);
      check("rd_ready_out", {31'b0, rd_ready_out}, {31'b0, exp_ready});
      acc = rd_valid_in && exp_ready;
      if (acc) sb_q.push_back({p, (rd_size == 2'b00 && rd_addr >= 3'd4), rd_size});
      @(posedge clk);
      #1;
      if (wr_en) begin
         case (wr_size)
            2'b10: exp_regs[wr_addr] = wr_data;
            2'b01: exp_regs[wr_addr][15:0] = wr_data[15:0];
            2'b00: if (wr_addr >= 3'd4) exp_regs[wr_addr - 3'd4][15:8] = wr_data[7:0];
                   else                 exp_regs[wr_addr][7:0] = wr_data[7:0];
            default: ;
         endcase
      end
`ifdef GPR_SCOREBOARD_EN
      if (wr_en && wr_size != 2'b11) exp_busy[phys(wr_addr, wr_size)] = 1'b0;
      if (alloc_en) exp_busy[alloc_addr] = 1'b1;
`endif
      if (acc) begin
         exp_valid = 1'b1;
         if (rd_valid_out && sb_q.size() > 0) cur = sb_q.pop_front();
         else check("sb_output_missing", {31'b0, rd_valid_out}, 32'd1);
      end else if (exp_valid && rd_ready_in) begin
         exp_valid = 1'b0;
      end
      check("rd_valid_out", {31'b0, rd_valid_out}, {31'b0, exp_valid});
      check("busy", {24'b0, busy}, {24'b0, exp_busy});
      if (exp_valid) begin
         check("rd_sel", {29'b0, rd_sel}, {29'b0, cur[5:3]});
         check("rd_hi_byte", {31'b0, rd_hi_byte}, {31'b0, cur[2]});
         check("rd_size_out", {30'b0, rd_size_out}, {30'b0, cur[1:0]});
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [1:0] s, input logic [31:0] d);
      clr();
      wr_en = 1'b1; wr_addr = a; wr_size = s; wr_data = d;
      step();
      clr();
   endtask

   task automatic rd(input logic [2:0] a, input logic [1:0] s);
      rd_valid_in = 1'b1; rd_addr = a; rd_size = s;
   endtask

   task automatic reset_model();
      for (int i = 0; i < 8; i++) exp_regs[i] = 32'h0;
      exp_busy = 8'h00;
      exp_valid = 1'b0;
      sb_q.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; rd_ready_in = 1'b1;
      wr_addr = 3'd0; wr_size = 2'b00; wr_data = 32'h0;
      rd_addr = 3'd0; rd_size = 2'b00; alloc_addr = 3'd0;
      clr();
      reset_model();
      cur = 6'h0;
      repeat (2) @(posedge clk);
      #1;
      check_regs("reset");
      check("reset_valid", {31'b0, rd_valid_out}, 32'd0);
      check("reset_sel", {29'b0, rd_sel}, 32'd0);
      check("reset_hi", {31'b0, rd_hi_byte}, 32'd0);
      check("reset_size", {30'b0, rd_size_out}, 32'd0);
      check("reset_busy", {24'b0, busy}, 32'd0);
      rst_n = 1'b1;

      // Size-aware writes to R2
      wr(3'd2, 2'b10, 32'hDEAD_BEEF);
      check("r2_dword", r2, 32'hDEAD_BEEF);
      wr(3'd2, 2'b01, 32'h0000_1234);
      check("r2_word", r2, 32'hDEAD_1234);
      wr(3'd6, 2'b00, 32'h0000_00AA);
      check("r2_dh", r2, 32'hDEAD_AA34);
      wr(3'd2, 2'b00, 32'h0000_0055);
      check("r2_dl", r2, 32'hDEAD_AA55);
      wr(3'd2, 2'b11, 32'hFFFF_FFFF);
      check("r2_reserved", r2, 32'hDEAD_AA55);
      wr(3'd7, 2'b00, 32'h0000_0077);
      check_regs("writes");

      // Address mapping, back-to-back reads
      rd_ready_in = 1'b1;
      rd(3'd7, 2'b00); step();
      rd(3'd7, 2'b10); step();
      clr(); step();

      // Back-pressure: stage fills, holds 3 cycles, then refills with no bubble
      rd_ready_in = 1'b0;
      rd(3'd1, 2'b10); step();
      rd(3'd4, 2'b01);
      repeat (3) step();
      rd_ready_in = 1'b1;
      step();
      clr(); step();

      // Same-cycle write and read of R5
      wr_en = 1'b1; wr_addr = 3'd5; wr_size = 2'b10; wr_data = 32'h0000_0042;
      rd(3'd5, 2'b10);
      rd_ready_in = 1'b0;
      step();
      clr();
      check("mux_same_cycle", rv[rd_sel], 32'h0000_0042);
      // Write while the stage is held: the mux follows the register
      wr(3'd5, 2'b10, 32'h0000_0099);
      check("mux_held_write", rv[rd_sel], 32'h0000_0099);
      rd_ready_in = 1'b1;
      step();

`ifdef GPR_SCOREBOARD_EN
      alloc_en = 1'b1; alloc_addr = 3'd1; step(); clr();
      rd(3'd1, 2'b10); step();
      wr_en = 1'b1; wr_addr = 3'd1; wr_size = 2'b10; wr_data = 32'h1111_2222;
      step();
      wr_en = 1'b0;
      step();
      clr(); step();
      alloc_en = 1'b1; alloc_addr = 3'd1;
      wr_en = 1'b1; wr_addr = 3'd1; wr_size = 2'b10; wr_data = 32'h3333_4444;
      step(); clr();
      check("busy1_alloc_wins", {31'b0, busy[1]}, 32'd1);
`else
      alloc_en = 1'b1; alloc_addr = 3'd1;
      rd(3'd1, 2'b10); step();
      clr(); step();
`endif
      check_regs("pre_reset");

      // Reset mid-read: valid drops without a clock edge
      rd_ready_in = 1'b0;
      rd(3'd3, 2'b01); step();
      clr();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_reset_valid", {31'b0, rd_valid_out}, 32'd0);
      check("async_reset_r2", r2, 32'h0);
      reset_model();
      @(posedge clk); #1;
      rst_n = 1'b1;
      rd_ready_in = 1'b1;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
